jtag_phy: RTL and testbench
===========================

# jtag_phy

- Bit-level JTAG engine directly downstream of the ADIv5 JTAG command layer.
- Accepts PHY command words through an internal command FIFO and drives TCK/TMS/TDI; TDO is sampled into a capture register.
- Scan commands run the TAP through Shift-IR/Shift-DR. Length-0 commands perform TAP reset, SWD-to-JTAG switch and idle flush.
- Only read commands return captured data, through an internal response FIFO.

## Interface
- FIFO_AW, 2, log2 depth of both internal FIFOs (codebase `fifo`)
- CLK_DIV, 4, CLK cycles per TCK half-period (≥1)
- IDLE_CYCLES, 8, Run-Test/Idle clocks appended by AUTO and FLUSH commands
- JTAG_CMD_WIDTH, 79, command word width
- JTAG_RESP_WIDTH, 70, response word width
- CLK  in  1  sole clock; everything is synchronous to its rising edge
- RESET  in  1  synchronous, active-high
- WRDATA  in  JTAG_CMD_WIDTH  [2:0]=CMD, [14:3]=LEN, [49:15]=DAT[34:0], [78:50] ignored
- WREN  in  1  push command
- WRFULL  out  1  command FIFO full
- RDDATA  out  JTAG_RESP_WIDTH  [69:35]=CAP[34:0], [34:0]=DAT echo of the originating command
- RDEN  in  1  pop response; RDDATA is valid the cycle after RDEN
- RDEMPTY  out  1  response FIFO empty
- TCK  out  1  JTAG clock
- TMS  out  1  JTAG mode select
- TDI  out  1  JTAG data to target
- TDO  in  1  JTAG data from target

## Operation
- **CMD encoding:** bit0=READ, bit1=AUTO, bit2=IR (1=IR scan, 0=DR scan).
- **LEN==0 special commands:**
  - CMD 000, RESET: TMS=1 for 6 TCK, then TMS=0 for 1 TCK. Ends in Run-Test/Idle (RTI).
  - CMD 100, SWITCH: TMS=1 ×56; 16-bit 0xE73C on TMS, LSB first; TMS=1 ×6; TMS=0 ×1. Ends in RTI.
  - CMD 110, FLUSH: TMS=0 for IDLE_CYCLES TCK.
  - All other LEN==0 codes: consumed with no pin activity.
  - No special command produces a response.
- **LEN>0 scans:** the TAP starts and ends in RTI.
  - Entry: TMS sequence 1,0,0 for DR; 1,1,0,0 for IR.
  - Shift: LEN bits with TMS=0, except the last bit, which has TMS=1 (→Exit1).
  - Exit: TMS 1 (Update), then TMS 0 (RTI).
  - If AUTO: IDLE_CYCLES extra TCK with TMS=0.
- **TDI during shift:** shift bit i (0-based) drives DAT[i] for i<35, else 1. Outside shift, TDI=1.
- **Capture:** CAP is a 35-bit register cleared at command start. Each shift bit's TDO is sampled, CAP shifts right by one and the sample enters CAP[34].
  - After LEN shifts, the first TDO bit sits at CAP[35−LEN] for LEN≤35.
  - For LEN>35, CAP holds the last 35 bits.
- **Response:** READ commands with LEN>0 push {CAP, DAT} after the final RTI clock (after the AUTO idle, if any). Write commands push nothing.
- **FSM states:**
  - IDLE: command FIFO non-empty → pop, go to LOAD.
  - LOAD: latch command; LEN==0 → SEQ; LEN>0 → ENTRY.
  - SEQ: run the special TMS pattern.
  - ENTRY → SHIFT → EXIT → (AUTO) RUNIDLE.
  - RESP: wait while the response FIFO is full (TCK held low), push, → IDLE.
  - After SEQ or a non-read scan, return to IDLE.
- **Backpressure:** a full response FIFO stalls only the RESP state. Bit timing within a command is never stretched.

## Timing
- **TCK:** idles low. One TCK bit = 2×CLK_DIV CLK cycles.
  - TMS/TDI update on the CLK cycle where TCK falls (or at bit start).
  - TDO is sampled on the CLK cycle where TCK rises.
  - TCK rises after CLK_DIV cycles.
- **Start latency:** first TCK rising edge occurs CLK_DIV+2 cycles after the WREN that makes an idle, empty block non-empty.
- **Back-to-back commands:** consecutive commands are separated by exactly 2 CLK cycles of TCK low (IDLE+LOAD).
- **Scan duration:** DR scan of LEN bits, no AUTO = (LEN+5) TCK. IR scan = (LEN+6) TCK.
- **RESET values:** TCK=0, TMS=1, TDI=1, WRFULL=0, RDEMPTY=1. FSM→IDLE; both FIFOs emptied; CAP=0. No TAP reset sequence is driven.
- **RESET mid-command:** aborts on the next CLK; pins take their reset values the same cycle; no response is pushed.
- **Simultaneous events:** WREN with WRFULL high drops the word. Simultaneous WREN and internal pop on a full FIFO is accepted.

## Test plan
- **RESET command:** CMD=000, LEN=0 → TMS 1,1,1,1,1,1,0 over 7 TCK; RDEMPTY stays 1.
- **IDCODE read:** CMD=001, LEN=32, TDO model returns 0x4BA00477 LSB first → one response with RDDATA[69:38]=0x4BA00477; 37 TCK total.
- **DPACC write:** CMD=000, LEN=35, DAT=0x1_2345_6782 → TDI matches DAT LSB-first; TMS=1 only on Select-DR, the last shift bit, and Update; no response.
- **IR write with AUTO + CLK_DIV:** CMD=110, LEN=4, DAT=0xB, IDLE_CYCLES=8 → TDI 1,1,0,1; TMS 1,1,0,0,0,0,0,1,1,0 then 8 zeros; TCK period 8 CLK with CLK_DIV=4.
- **SWITCH:** CMD=100, LEN=0 → 56 ones, 0xE73C LSB-first, 6 ones, 0 on TMS (79 TCK); TDI=1 throughout.
- **Backpressure and reset:** queue 6 DR reads with RDEN=0, FIFO_AW=2 → 4 responses stored; FSM holds in RESP with TCK low. Assert RESET mid-shift on the next command → TCK=0, TMS=1 the same cycle; RDEMPTY=1.

Source files
------------

// File: rtl/jtag_phy.sv
// jtag_phy: bit-level JTAG engine. Pops PHY command words from a small
// command FIFO, sequences TCK/TMS/TDI for scans and special TMS patterns,
// captures TDO during shift and returns {CAP, DAT} for read scans through
// a response FIFO.
module jtag_phy #(
  parameter int FIFO_AW         = 2,
  parameter int CLK_DIV         = 4,
  parameter int IDLE_CYCLES     = 8,
  parameter int JTAG_CMD_WIDTH  = 79,
  parameter int JTAG_RESP_WIDTH = 70
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [JTAG_CMD_WIDTH-1:0]  WRDATA,
  input  logic                       WREN,
  output logic                       WRFULL,
  output logic [JTAG_RESP_WIDTH-1:0] RDDATA,
  input  logic                       RDEN,
  output logic                       RDEMPTY,
  output logic                       TCK,
  output logic                       TMS,
  output logic                       TDI,
  input  logic                       TDO
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = 50;
  localparam int DIVW  = $clog2(2 * CLK_DIV) + 1;
  localparam logic [15:0] SWITCH_PAT = 16'hE73C;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SEQ, ST_ENTRY, ST_SHIFT, ST_EXIT, ST_RUNIDLE, ST_RESP
  } state_e;

  // Bits above the DAT field carry nothing for this engine.
  logic unused_wrdata;
  assign unused_wrdata = ^WRDATA[JTAG_CMD_WIDTH-1:CW];

  // ---------------- command FIFO ----------------
  logic [CW-1:0]    cmd_mem [DEPTH];
  logic [FIFO_AW:0] cmd_wp_q, cmd_rp_q;
  logic [FIFO_AW:0] cmd_count;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CW-1:0]    cmd_head;

  // ---------------- response FIFO ----------------
  logic [JTAG_RESP_WIDTH-1:0] rsp_mem [DEPTH];
  logic [FIFO_AW:0]           rsp_wp_q, rsp_rp_q;
  logic [FIFO_AW:0]           rsp_count;
  logic                       rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [JTAG_RESP_WIDTH-1:0] rd_q;

  // ---------------- engine ----------------
  state_e          state_q;
  logic [DIVW-1:0] div_q;
  logic [15:0]     idx_q;
  logic [2:0]      cmd_q;
  logic [11:0]     len_q;
  logic [34:0]     dat_q;
  logic [34:0]     cap_q;
  logic            tck_q, tms_q, tdi_q;

  state_e          bit_state_d, load_state_d, pin_state;
  logic [15:0]     bit_idx_d, pin_idx;
  logic            pin_tms, pin_tdi;
  logic [63:0]     dat_ext;

  assign cmd_count = cmd_wp_q - cmd_rp_q;
  assign cmd_full  = (cmd_count == (FIFO_AW+1)'(DEPTH));
  assign cmd_empty = (cmd_wp_q == cmd_rp_q);
  assign cmd_pop   = (state_q == ST_IDLE) && !cmd_empty;
  // A full FIFO still accepts a word in the same cycle the engine pops one.
  assign cmd_push  = WREN && (!cmd_full || cmd_pop);
  assign cmd_head  = cmd_mem[cmd_rp_q[FIFO_AW-1:0]];

  assign rsp_count = rsp_wp_q - rsp_rp_q;
  assign rsp_full  = (rsp_count == (FIFO_AW+1)'(DEPTH));
  assign rsp_empty = (rsp_wp_q == rsp_rp_q);
  assign rsp_push  = (state_q == ST_RESP) && !rsp_full;
  assign rsp_pop   = RDEN && !rsp_empty;

  assign WRFULL  = cmd_full;
  assign RDEMPTY = rsp_empty;
  assign RDDATA  = rd_q;
  assign TCK     = tck_q;
  assign TMS     = tms_q;
  assign TDI     = tdi_q;

  // Shift bits beyond DAT[34] drive a constant 1.
  assign dat_ext = {{29{1'b1}}, dat_q};

  function automatic logic [15:0] seq_len(input logic [2:0] code);
    case (code)
      3'b000:  return 16'd7;
      3'b100:  return 16'd79;
      3'b110:  return 16'(IDLE_CYCLES);
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic seq_tms(input logic [2:0] code, input logic [15:0] i);
    logic [15:0] k;
    k = i - 16'd56;
    case (code)
      3'b000: return (i < 16'd6);
      3'b100: begin
        if (i < 16'd56)      return 1'b1;
        else if (i < 16'd72) return SWITCH_PAT[k[3:0]];
        else if (i < 16'd78) return 1'b1;
        else                 return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Command FIFO storage.
  always_ff @(posedge CLK) begin
    if (cmd_push) cmd_mem[cmd_wp_q[FIFO_AW-1:0]] <= WRDATA[CW-1:0];
  end

  // Command FIFO pointers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_wp_q <= '0;
      cmd_rp_q <= '0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge CLK) begin
    if (rsp_push) rsp_mem[rsp_wp_q[FIFO_AW-1:0]] <= JTAG_RESP_WIDTH'({cap_q, dat_q});
  end

  // Response FIFO pointers and registered read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_wp_q <= '0;
      rsp_rp_q <= '0;
      rd_q     <= '0;
    end else begin
      if (rsp_push) rsp_wp_q <= rsp_wp_q + 1'b1;
      if (rsp_pop) begin
        rsp_rp_q <= rsp_rp_q + 1'b1;
        rd_q     <= rsp_mem[rsp_rp_q[FIFO_AW-1:0]];
      end
    end
  end

  // Next bit position at the end of a TCK bit, plus pin values for the bit
  // that starts next (pins are computed one bit ahead so they change with
  // the TCK falling edge or at the first bit of a command).
  always_comb begin
    bit_state_d = state_q;
    bit_idx_d   = idx_q + 16'd1;
    case (state_q)
      ST_SEQ:
        if (idx_q == seq_len(cmd_q) - 16'd1) begin
          bit_state_d = ST_IDLE;
          bit_idx_d   = '0;
        end
      ST_ENTRY:
        if (idx_q == (cmd_q[2] ? 16'd3 : 16'd2)) begin
          bit_state_d = ST_SHIFT;
          bit_idx_d   = '0;
        end
      ST_SHIFT:
        if (idx_q == {4'b0, len_q} - 16'd1) begin
          bit_state_d = ST_EXIT;
          bit_idx_d   = '0;
        end
      ST_EXIT:
        if (idx_q == 16'd1) begin
          bit_idx_d = '0;
          if (cmd_q[1] && (IDLE_CYCLES > 0)) bit_state_d = ST_RUNIDLE;
          else if (cmd_q[0])                 bit_state_d = ST_RESP;
          else                               bit_state_d = ST_IDLE;
        end
      ST_RUNIDLE:
        if (idx_q == 16'(IDLE_CYCLES - 1)) begin
          bit_idx_d   = '0;
          bit_state_d = cmd_q[0] ? ST_RESP : ST_IDLE;
        end
      default: ;
    endcase

    if (len_q != 12'd0)                load_state_d = ST_ENTRY;
    else if (seq_len(cmd_q) != 16'd0)  load_state_d = ST_SEQ;
    else                               load_state_d = ST_IDLE;

    pin_state = (state_q == ST_LOAD) ? load_state_d : bit_state_d;
    pin_idx   = (state_q == ST_LOAD) ? 16'd0 : bit_idx_d;

    pin_tms = tms_q;
    pin_tdi = 1'b1;
    case (pin_state)
      ST_SEQ:     pin_tms = seq_tms(cmd_q, pin_idx);
      ST_ENTRY:   pin_tms = (pin_idx == 16'd0) || (cmd_q[2] && (pin_idx == 16'd1));
      ST_SHIFT: begin
        pin_tms = (pin_idx == {4'b0, len_q} - 16'd1);
        pin_tdi = (pin_idx[15:6] == '0) ? dat_ext[pin_idx[5:0]] : 1'b1;
      end
      ST_EXIT:    pin_tms = (pin_idx == 16'd0);
      ST_RUNIDLE: pin_tms = 1'b0;
      default: ;
    endcase
  end

  // Engine FSM: command decode, TCK divider, pin and capture registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      dat_q   <= '0;
      cap_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:
          if (!cmd_empty) begin
            cmd_q   <= cmd_head[2:0];
            len_q   <= cmd_head[14:3];
            dat_q   <= cmd_head[49:15];
            state_q <= ST_LOAD;
          end
        ST_LOAD: begin
          cap_q   <= '0;
          idx_q   <= '0;
          div_q   <= '0;
          state_q <= load_state_d;
          tms_q   <= pin_tms;
          tdi_q   <= pin_tdi;
        end
        ST_SEQ, ST_ENTRY, ST_SHIFT, ST_EXIT, ST_RUNIDLE: begin
          if (div_q == DIVW'(CLK_DIV - 1)) begin
            tck_q <= 1'b1;
            div_q <= div_q + 1'b1;
            if (state_q == ST_SHIFT) cap_q <= {TDO, cap_q[34:1]};
          end else if (div_q == DIVW'(2 * CLK_DIV - 1)) begin
            tck_q   <= 1'b0;
            div_q   <= '0;
            state_q <= bit_state_d;
            idx_q   <= bit_idx_d;
            tms_q   <= pin_tms;
            tdi_q   <= pin_tdi;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_RESP:
          if (!rsp_full) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_phy.sv
// tb_jtag_phy: directed bench for jtag_phy. A monitor records TMS/TDI on
// every TCK rise and plays a TDO pattern; expected pin sequences and
// responses are built from the command encoding and compared afterwards.
module tb_jtag_phy;
  localparam int FIFO_AW     = 2;
  localparam int CLK_DIV     = 4;
  localparam int IDLE_CYCLES = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [78:0] WRDATA;
  logic        WREN, RDEN;
  logic        WRFULL, RDEMPTY;
  logic [69:0] RDDATA;
  logic        TCK, TMS, TDI, TDO;

  jtag_phy #(
    .FIFO_AW(FIFO_AW), .CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES),
    .JTAG_CMD_WIDTH(79), .JTAG_RESP_WIDTH(70)
  ) dut (
    .CLK(CLK), .RESET(RESET), .WRDATA(WRDATA), .WREN(WREN), .WRFULL(WRFULL),
    .RDDATA(RDDATA), .RDEN(RDEN), .RDEMPTY(RDEMPTY),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CLK = ~CLK;

  int checks;
  int failures;
  int cyc;
  int rise_cnt;
  int push_cyc;
  int base;
  logic tck_prev;
  logic rec_tms[$];
  logic rec_tdi[$];
  int   rise_t[$];
  logic exp_tms[$];
  logic exp_tdi[$];
  logic [69:0] sb[$];
  int tdo_base;
  int tdo_per = 1000;
  int tdo_off = 3;
  logic [63:0] tdo_pat;

  always @(posedge CLK) cyc = cyc + 1;

  // Pin monitor and TDO source: TDO for rise n is presented before that rise.
  always @(negedge CLK) begin : mon
    int rel;
    if (TCK === 1'b1 && tck_prev === 1'b0) begin
      rec_tms.push_back(TMS);
      rec_tdi.push_back(TDI);
      rise_t.push_back(cyc);
      rise_cnt = rise_cnt + 1;
    end
    tck_prev = TCK;
    rel = ((rise_cnt - tdo_base) % tdo_per) - tdo_off;
    TDO = (rel >= 0 && rel < 64) ? tdo_pat[rel] : 1'b0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_bit(input logic m, input logic t);
    exp_tms.push_back(m);
    exp_tdi.push_back(t);
  endtask

  task automatic model_cmd(input logic [2:0] c, input int l, input logic [34:0] d);
    logic [15:0] sw;
    sw = 16'hE73C;
    if (l == 0) begin
      case (c)
        3'b000: begin
          for (int i = 0; i < 6; i++) add_bit(1'b1, 1'b1);
          add_bit(1'b0, 1'b1);
        end
        3'b100: begin
          for (int i = 0; i < 56; i++) add_bit(1'b1, 1'b1);
          for (int i = 0; i < 16; i++) add_bit(sw[i], 1'b1);
          for (int i = 0; i < 6; i++) add_bit(1'b1, 1'b1);
          add_bit(1'b0, 1'b1);
        end
        3'b110: for (int i = 0; i < IDLE_CYCLES; i++) add_bit(1'b0, 1'b1);
        default: ;
      endcase
    end else begin
      add_bit(1'b1, 1'b1);
      if (c[2]) add_bit(1'b1, 1'b1);
      add_bit(1'b0, 1'b1);
      add_bit(1'b0, 1'b1);
      for (int i = 0; i < l; i++) begin
        if (i < 35) add_bit(i == l - 1, d[i]);
        else        add_bit(i == l - 1, 1'b1);
      end
      add_bit(1'b1, 1'b1);
      add_bit(1'b0, 1'b1);
      if (c[1]) for (int i = 0; i < IDLE_CYCLES; i++) add_bit(1'b0, 1'b1);
    end
  endtask

  // First TDO bit lands at CAP[35-len]; long scans keep the last 35 bits.
  function automatic logic [34:0] exp_cap(input int len, input logic [63:0] pat);
    logic [63:0] v;
    if (len <= 35) v = (pat & ((64'd1 << len) - 64'd1)) << (35 - len);
    else           v = pat >> (len - 35);
    return v[34:0];
  endfunction

  task automatic push_cmd(input logic [2:0] c, input logic [11:0] l, input logic [34:0] d);
    @(negedge CLK);
    WRDATA = {29'h0, d, l, c};
    WREN   = 1'b1;
    @(negedge CLK);
    WREN     = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic begin_test();
    exp_tms.delete();
    exp_tdi.delete();
    base     = rise_cnt;
    tdo_base = rise_cnt;
  endtask

  task automatic check_seq(input string tag);
    logic [127:0] ov, ev, ot, et;
    ov = '0; ev = '0; ot = '0; et = '0;
    for (int i = 0; i < exp_tms.size(); i++) begin
      ev[i] = exp_tms[i];
      et[i] = exp_tdi[i];
      if (base + i < rec_tms.size()) begin
        ov[i] = rec_tms[base + i];
        ot[i] = rec_tdi[base + i];
      end
    end
    chk({tag, "_bits"}, rise_cnt - base, exp_tms.size());
    chk({tag, "_tms"}, ov, ev);
    chk({tag, "_tdi"}, ot, et);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while (rise_cnt < base + n && k < n * 2 * CLK_DIV + 200) begin
      @(posedge CLK);
      k++;
    end
    repeat (2 * CLK_DIV + 6) @(posedge CLK);
    check_seq(tag);
    @(negedge CLK);
  endtask

  task automatic pop_check(input string tag);
    int k;
    logic [69:0] e;
    k = 0;
    while (RDEMPTY && k < 400) begin
      @(posedge CLK);
      k++;
    end
    @(negedge CLK);
    RDEN = 1'b1;
    @(negedge CLK);
    RDEN = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk(tag, RDDATA, e);
  endtask

  initial begin
    int k, pmin, pmax, p, rst_mark;
    logic [34:0] d;
    RESET = 1'b1; WREN = 1'b0; RDEN = 1'b0; WRDATA = '0; tdo_pat = '0;
    repeat (3) @(negedge CLK);
    chk("rst_tck", TCK, 1'b0);
    chk("rst_tms", TMS, 1'b1);
    chk("rst_tdi", TDI, 1'b1);
    chk("rst_wrfull", WRFULL, 1'b0);
    chk("rst_rdempty", RDEMPTY, 1'b1);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // TAP reset special command, also checks start latency
    begin_test();
    model_cmd(3'b000, 0, '0);
    push_cmd(3'b000, 12'd0, '0);
    wait_done("reset_cmd", 7);
    chk("reset_latency", (rise_t.size() > base) ? rise_t[base] - push_cyc : -1, CLK_DIV + 2);
    chk("reset_rdempty", RDEMPTY, 1'b1);

    // IDCODE read
    begin_test();
    tdo_pat = 64'h4BA00477; tdo_off = 3;
    d = 35'h5_A5A5_A5A5;
    model_cmd(3'b001, 32, d);
    sb.push_back({exp_cap(32, tdo_pat), d});
    push_cmd(3'b001, 12'd32, d);
    wait_done("idcode", 37);
    pop_check("idcode_resp");
    chk("idcode_field", RDDATA[69:38], 32'h4BA00477);
    chk("idcode_rdempty", RDEMPTY, 1'b1);

    // DPACC write, full 35-bit shift
    begin_test();
    d = 35'h1_2345_6782;
    model_cmd(3'b000, 35, d);
    push_cmd(3'b000, 12'd35, d);
    wait_done("dpacc_wr", 40);
    chk("dpacc_rdempty", RDEMPTY, 1'b1);

    // IR write with AUTO idle, TCK period
    begin_test();
    model_cmd(3'b110, 4, 35'hB);
    push_cmd(3'b110, 12'd4, 35'hB);
    wait_done("ir_auto", 18);
    pmin = 1000; pmax = 0;
    for (int i = base + 1; i < base + 18 && i < rise_t.size(); i++) begin
      p = rise_t[i] - rise_t[i - 1];
      if (p < pmin) pmin = p;
      if (p > pmax) pmax = p;
    end
    chk("ir_period_min", pmin, 2 * CLK_DIV);
    chk("ir_period_max", pmax, 2 * CLK_DIV);
    chk("ir_rdempty", RDEMPTY, 1'b1);

    // SWD-to-JTAG switch
    begin_test();
    model_cmd(3'b100, 0, '0);
    push_cmd(3'b100, 12'd0, '0);
    wait_done("switch", 79);

    // Idle flush, then an unused LEN==0 code
    begin_test();
    model_cmd(3'b110, 0, '0);
    push_cmd(3'b110, 12'd0, '0);
    wait_done("flush", IDLE_CYCLES);
    begin_test();
    push_cmd(3'b011, 12'd0, 35'h7);
    repeat (40) @(negedge CLK);
    wait_done("nop_len0", 0);
    chk("nop_rdempty", RDEMPTY, 1'b1);

    // Long read: CAP keeps only the last 35 TDO bits, TDI=1 past DAT[34]
    begin_test();
    tdo_pat = 64'hDEAD_BEEF_CAFE_F00D; tdo_off = 3;
    d = 35'h7_0F0F_1234;
    model_cmd(3'b001, 40, d);
    sb.push_back({exp_cap(40, tdo_pat), d});
    push_cmd(3'b001, 12'd40, d);
    wait_done("long_rd", 45);
    pop_check("long_rd_resp");

    // Back-to-back commands: 2 extra CLK between bits across the boundary
    begin_test();
    model_cmd(3'b000, 0, '0);
    model_cmd(3'b000, 0, '0);
    push_cmd(3'b000, 12'd0, '0);
    push_cmd(3'b000, 12'd0, '0);
    wait_done("b2b", 14);
    chk("b2b_gap", (rise_t.size() > base + 7) ? rise_t[base + 7] - rise_t[base + 6] : -1,
        2 * CLK_DIV + 2);

    // Backpressure: six 8-bit DR reads with nothing drained
    begin_test();
    tdo_per = 13; tdo_off = 3; tdo_pat = 64'hC5;
    for (int j = 0; j < 6; j++) begin
      d = 35'h100 + 35'(j);
      sb.push_back({exp_cap(8, tdo_pat), d});
      if (j == 5) begin
        k = 0;
        while (WRFULL && k < 400) begin
          @(posedge CLK);
          k++;
        end
      end
      push_cmd(3'b001, 12'd8, d);
      if (j == 4) chk("bp_wrfull_set", WRFULL, 1'b1);
    end
    k = 0;
    while (rise_cnt < base + 65 && k < 2000) begin
      @(posedge CLK);
      k++;
    end
    repeat (300) @(posedge CLK);
    @(negedge CLK);
    chk("bp_stall_bits", rise_cnt - base, 65);
    chk("bp_stall_tck", TCK, 1'b0);
    chk("bp_rdempty", RDEMPTY, 1'b0);
    chk("bp_wrfull_clr", WRFULL, 1'b0);
    pop_check("bp_resp0");
    k = 0;
    while (rise_cnt < base + 71 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    chk("bp_pre_rst_tck", TCK, 1'b1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_tck", TCK, 1'b0);
    chk("midrst_tms", TMS, 1'b1);
    chk("midrst_tdi", TDI, 1'b1);
    chk("midrst_rdempty", RDEMPTY, 1'b1);
    chk("midrst_wrfull", WRFULL, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    rst_mark = rise_cnt;
    repeat (200) @(negedge CLK);
    chk("post_rst_quiet", rise_cnt - rst_mark, 0);
    chk("post_rst_rdempty", RDEMPTY, 1'b1);

    // Recovery: short read after the abort
    tdo_per = 1000;
    begin_test();
    tdo_pat = 64'h16; tdo_off = 3;
    d = 35'h2_4681_3579;
    model_cmd(3'b001, 5, d);
    sb.push_back({exp_cap(5, tdo_pat), d});
    push_cmd(3'b001, 12'd5, d);
    wait_done("recover", 10);
    pop_check("recover_resp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
